conv_output_serializer: RTL

- Sits directly downstream of the parallel convolutional encoder.
- Drains the encoder's three parity output FIFOs (d0/d1/d2 byte streams, one shared read request) once a block has finished encoding.
- Emits one framed byte stream to the rate-matching stage using a valid/ready handshake, in triplet order d0,d1,d2 per FIFO word.
- Block size is chosen by the encoder's length flag: 132 or 768 bytes per stream.

---
 rtl/encoder_pkg.sv | 20 ++
 rtl/triplet_hold_reg.sv | 41 ++++
 rtl/conv_output_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and types for the convolutional encoder output path.
package encoder_pkg;

  localparam int unsigned SMALL_BYTES_DEF = 132;
  localparam int unsigned LARGE_BYTES_DEF = 768;

  localparam logic [1:0] SID_D0 = 2'd0;
  localparam logic [1:0] SID_D1 = 2'd1;
  localparam logic [1:0] SID_D2 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_EMIT0,
    ST_EMIT1,
    ST_EMIT2
  } ser_state_e;

endpackage

// File: rtl/triplet_hold_reg.sv
// Holds one d0/d1/d2 FIFO triplet while it is emitted and muxes out the byte for the current stream id.
// Capture takes one cycle; the register is stable until the next capture, which keeps data steady under stall.
module triplet_hold_reg
  import encoder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] q0_i,
  input  logic [DATA_W-1:0] q1_i,
  input  logic [DATA_W-1:0] q2_i,
  input  logic [1:0]        sid_i,
  output logic [DATA_W-1:0] byte_o
);

  logic [DATA_W-1:0] d0_q, d1_q, d2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else if (capture_i) begin
      d0_q <= q0_i;
      d1_q <= q1_i;
      d2_q <= q2_i;
    end
  end

  always_comb begin
    byte_o = d0_q;
    case (sid_i)
      SID_D1:  byte_o = d1_q;
      SID_D2:  byte_o = d2_q;
      default: byte_o = d0_q;
    endcase
  end

endmodule

// File: rtl/conv_output_serializer.sv
// Drains the three parity FIFOs of a finished block as one framed d0,d1,d2 byte stream, 5 cycles per triplet.
// Emit states hold under backpressure; no FIFO read issues while a triplet is un-emitted. SERIALIZER_STATUS_EN adds err_overrun/blk_count.
module conv_output_serializer
  import encoder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SMALL_BYTES = SMALL_BYTES_DEF,
  parameter int LARGE_BYTES = LARGE_BYTES_DEF,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              computation_done,
  input  logic              length_in,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  output logic              rdreq_subblock,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_sid,
  output logic              busy
`ifdef SERIALIZER_STATUS_EN
  ,
  output logic              err_overrun,
  output logic [15:0]       blk_count
`endif
);

  localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(SMALL_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_LARGE = CNT_W'(LARGE_BYTES - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic              pend_q, pend_d;
  logic              pend_len_q, pend_len_d;
  logic              capture;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    rdreq_subblock = 1'b0;
    capture        = 1'b0;
    out_valid      = 1'b0;
    out_sid        = SID_D0;
    out_sop        = 1'b0;
    out_eop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A queued block is older than a fresh pulse, so it goes first.
        if (pend_q || computation_done) begin
          state_d = ST_READ;
          cnt_d   = '0;
          last_d  = (pend_q ? pend_len_q : length_in) ? LAST_LARGE : LAST_SMALL;
        end
      end
      ST_READ: begin
        rdreq_subblock = 1'b1;
        state_d        = ST_CAPT;
      end
      ST_CAPT: begin
        capture = 1'b1;
        state_d = ST_EMIT0;
      end
      ST_EMIT0: begin
        out_valid = 1'b1;
        out_sid   = SID_D0;
        out_sop   = (cnt_q == '0);
        if (out_ready) state_d = ST_EMIT1;
      end
      ST_EMIT1: begin
        out_valid = 1'b1;
        out_sid   = SID_D1;
        if (out_ready) state_d = ST_EMIT2;
      end
      ST_EMIT2: begin
        out_valid = 1'b1;
        out_sid   = SID_D2;
        out_eop   = (cnt_q == last_q);
        if (out_ready) begin
          if (cnt_q == last_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep queue for a block that finishes encoding while this one drains.
  always_comb begin
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    if (state_q == ST_IDLE) begin
      if (pend_q) begin
        pend_d = computation_done;
        if (computation_done) pend_len_d = length_in;
      end
    end else if (computation_done && !pend_q) begin
      pend_d     = 1'b1;
      pend_len_d = length_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  triplet_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture),
    .q0_i      (q0),
    .q1_i      (q1),
    .q2_i      (q2),
    .sid_i     (out_sid),
    .byte_o    (out_data)
  );

`ifdef SERIALIZER_STATUS_EN
  logic        err_q;
  logic [15:0] blk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      blk_q <= '0;
    end else begin
      if (computation_done && pend_q && (state_q != ST_IDLE)) err_q <= 1'b1;
      if (out_eop && out_ready) blk_q <= blk_q + 16'd1;
    end
  end

  assign err_overrun = err_q;
  assign blk_count   = blk_q;
`endif

endmodule
